dmem_initiator: RTL and testbench
=================================

# dmem_initiator

Bus initiator for the data memory's stall-handshake port. It accepts one load or store at a time from the pipeline over a valid/ready request channel. It drives address, data, size/sign mask and read/write strobes to the data memory, tracks the `clk_stall` handshake to completion and returns the load data or store acknowledgement on a one-cycle response strobe. It sits between the pipeline's memory stage and the data memory, and also owns watchdog detection of a responder that never completes.

## Interface

Parameters:
- `TIMEOUT`, default 16: maximum WAIT cycles before the transaction is aborted with a fault. Legal range 2..255.

Ports:
- `clk`  in  1  — the single clock; all state updates on its rising edge.
- `rst_n`  in  1  — reset, synchronous, active-low.
- `req_valid`  in  1  — request present.
- `req_ready`  out  1  — high only in IDLE.
- `req_we`  in  1  — 1 = store, 0 = load.
- `req_addr`  in  32  — byte address.
- `req_wdata`  in  32  — store data, right-aligned.
- `req_size`  in  2  — 00 = byte, 01 = halfword, 10 = word; 11 is treated as word.
- `req_signed`  in  1  — sign-extend load result.
- `resp_valid`  out  1  — one-cycle completion strobe.
- `resp_rdata`  out  32  — load result; 0 for stores and faults.
- `resp_fault`  out  1  — valid with `resp_valid`; set on timeout or misalignment.
- `mem_addr`  out  32  — to data memory `addr`.
- `mem_write_data`  out  32  — to `write_data`.
- `mem_memwrite`  out  1  — to `memwrite`.
- `mem_memread`  out  1  — to `memread`.
- `mem_sign_mask`  out  4  — to `sign_mask`.
- `mem_read_data`  in  32  — from `read_data`.
- `mem_clk_stall`  in  1  — from `clk_stall`.

## Operation

- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch addr, wdata, we and the mask.
  - Go to ISSUE, or to RESP with fault (see Configuration).
- **Mask encoding**
  - Byte → `{s,3'b001}`, halfword → `{s,3'b011}`, word → `{s,3'b111}`, where s=`req_signed`.
  - s is forced to 0 for stores.
- **ISSUE** (exactly one cycle)
  - Assert `mem_memread` (load) or `mem_memwrite` (store).
  - Clear `seen_stall` and the timeout counter.
  - Go to WAIT.
- **WAIT**
  - Both strobes low.
  - `mem_addr`, `mem_write_data` and `mem_sign_mask` held at the latched values.
  - Each cycle: set `seen_stall` if `mem_clk_stall`=1, and increment the counter.
  - When `seen_stall` && `mem_clk_stall`=0: capture `mem_read_data` (loads) or 0 (stores) and go to RESP with fault=0.
  - When the counter reaches `TIMEOUT` without completing: go to RESP with fault=1 and rdata=0.
- **RESP**
  - `resp_valid`=1 for exactly one cycle, with `resp_rdata`/`resp_fault` stable.
  - Go to IDLE.
  - No new request is accepted in the same cycle.
- Strobes are never asserted outside ISSUE. This guarantees the responder, on returning to its idle state, never re-samples a stale strobe.
- Counter is 8 bits and saturates; it never wraps.

## Timing

- **Reset values:** state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_fault`=0, all `mem_*` outputs 0.
- **Reset mid-operation:** `rst_n` low at any edge forces IDLE. No response is produced for the aborted transaction.
- **Cycle timeline**
  - Accept at edge E0.
  - ISSUE drives the strobe during E0→E1; the responder samples it at E1 and raises stall.
  - The responder completes at E2 and drops stall.
  - The initiator sees stall=0 at E3 and captures data.
  - `resp_valid` is high E3→E4.
- **Latency:** 4 cycles from accept to response. Throughput is one transaction per 5 cycles back-to-back.
- **Bus stability:** `mem_addr`/`mem_write_data`/`mem_sign_mask` change only on leaving IDLE and are held through RESP.
- **Request holding:** `req_*` inputs are ignored while `req_ready`=0; the requester need not hold them after acceptance.

## Configuration

- Macro: `DMEM_INIT_ALIGN_CHECK_EN`.
- **Defined:**
  - A halfword with `req_addr[0]`=1, or a word with `req_addr[1:0]`≠0, is accepted and goes IDLE→RESP directly with `resp_fault`=1 and `resp_rdata`=0.
  - No memory strobe is issued.
  - Latency is 1 cycle.
- **Undefined:** all requests are issued unchanged. The responder's byte-lane behaviour for misaligned accesses applies.

## Test plan

- **Word store then load:** store 0xDEADBEEF to 0x4010, then load a word from 0x4010 → second response `resp_rdata`=0xDEADBEEF, fault=0, `resp_valid` exactly 4 cycles after each accept.
- **Signed byte load:** memory word 0x000080FF, signed byte load at offset 1 → 0xFFFFFF80. The unsigned load at the same offset → 0x00000080.
- **Strobe discipline:** during every transaction `mem_memread`/`mem_memwrite` are high for exactly one cycle. Back-to-back loads produce no extra responder access (monitor counts stall pulses = requests).
- **Timeout:** hold `mem_clk_stall`=1 forever after ISSUE with `TIMEOUT`=16 → `resp_valid`+`resp_fault`=1, rdata=0, 16 WAIT cycles later, then `req_ready`=1. Also: stall never rises → same fault.
- **Reset mid-operation:** assert `rst_n`=0 during WAIT → next cycle IDLE, all outputs at reset values, no `resp_valid`. A new load after reset completes normally.
- **Misaligned word:** word load at 0x4002 with `DMEM_INIT_ALIGN_CHECK_EN` → fault after 1 cycle, no strobes. Without the macro → a normal 4-cycle access.

Source files
------------

// File: rtl/dmem_initiator.sv
// dmem_initiator: one-outstanding load/store initiator for the data
// memory stall-handshake port. Option macro: DMEM_INIT_ALIGN_CHECK_EN.
module dmem_initiator #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  mask_q;
  logic [3:0]  mask_d;
  logic [2:0]  lanes;
  logic        we_q;
  logic        fault_q;
  logic        seen_stall;
  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;
  logic        misalign;
  logic        accept;
  logic        done;
  logic        expired;

  // size to lane-mask decode; size 11 behaves as a word
  always_comb begin
    lanes = 3'b111;
    unique case (1'b1)
      (req_size == 2'b00): lanes = 3'b001;
      (req_size == 2'b01): lanes = 3'b011;
      default:             lanes = 3'b111;
    endcase
  end

  // stores never sign-extend
  assign mask_d = {req_signed & ~req_we, lanes};

`ifdef DMEM_INIT_ALIGN_CHECK_EN
  assign misalign =
    ((req_size == 2'b01) && req_addr[0]) ||
    (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign accept  = (state == S_IDLE) && req_valid;
  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign done    = seen_stall && !mem_clk_stall;
  assign expired = !done && (cnt_inc == TO_LIM);

  // next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid)
          state_nxt = misalign ? S_RESP : S_ISSUE;
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (done || expired)
          state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // request latch; bus fields hold from accept through RESP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      we_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      mask_q  <= mask_d;
      we_q    <= req_we;
    end
  end

  // handshake tracking and saturating watchdog count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_stall <= 1'b0;
      cnt        <= '0;
    end else if (state == S_ISSUE) begin
      seen_stall <= 1'b0;
      cnt        <= '0;
    end else if (state == S_WAIT) begin
      if (mem_clk_stall)
        seen_stall <= 1'b1;
      cnt <= cnt_inc;
    end
  end

  // response payload, loaded only on the edge that enters RESP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      rdata_q <= '0;
      fault_q <= 1'b0;
      if (accept && misalign) begin
        fault_q <= 1'b1;
      end else if (state == S_WAIT) begin
        if (done)
          rdata_q <= we_q ? 32'h0 : mem_read_data;
        else if (expired)
          fault_q <= 1'b1;
      end
    end
  end

  assign req_ready      = (state == S_IDLE);
  assign resp_valid     = (state == S_RESP);
  assign resp_rdata     = rdata_q;
  assign resp_fault     = fault_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_sign_mask  = mask_q;
  assign mem_memread    = (state == S_ISSUE) && !we_q;
  assign mem_memwrite   = (state == S_ISSUE) && we_q;

endmodule

// File: tb/tb_dmem_initiator.sv
// tb_dmem_initiator: directed bench for dmem_initiator with a
// stall-handshake data memory responder model.
module tb_dmem_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data = 32'h0;
  logic        mem_clk_stall = 1'b0;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int strobe_cyc = 0;
  int stall_pulses = 0;
  int resp_cnt = 0;
  int rmode = 0;

  logic [7:0]  bmem [256];
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_mask;

  typedef struct {
    logic        rdy;
    logic [31:0] rd;
    logic        flt;
    int          lat;
    int          strobes;
    logic [3:0]  mask;
    logic        hold;
    logic        one;
    int          acc;
  } res_t;

  dmem_initiator #(.TIMEOUT(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_fault     (resp_fault),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memwrite   (mem_memwrite),
    .mem_memread    (mem_memread),
    .mem_sign_mask  (mem_sign_mask),
    .mem_read_data  (mem_read_data),
    .mem_clk_stall  (mem_clk_stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_memread || mem_memwrite)
      strobe_cyc <= strobe_cyc + 1;
    if (resp_valid)
      resp_cnt <= resp_cnt + 1;
  end

  function automatic logic [31:0] rd_word(
    input logic [7:0] b, input logic [3:0] m);
    logic [31:0] d;
    d = {bmem[b + 8'd3], bmem[b + 8'd2],
         bmem[b + 8'd1], bmem[b]};
    case (m[2:0])
      3'b001: d = m[3] ? {{24{d[7]}}, d[7:0]}
                       : {24'h0, d[7:0]};
      3'b011: d = m[3] ? {{16{d[15]}}, d[15:0]}
                       : {16'h0, d[15:0]};
      default: ;
    endcase
    return d;
  endfunction

  // responder: raise stall on a strobe, complete one edge later
  // rmode 1 never completes, rmode 2 never stalls
  always @(posedge clk) begin
    if (!rst_n) begin
      mem_clk_stall <= 1'b0;
    end else if (!mem_clk_stall) begin
      if ((mem_memread || mem_memwrite) && rmode != 2) begin
        mem_clk_stall <= 1'b1;
        stall_pulses  <= stall_pulses + 1;
        r_we    <= mem_memwrite;
        r_addr  <= mem_addr;
        r_wdata <= mem_write_data;
        r_mask  <= mem_sign_mask;
      end
    end else if (rmode == 0) begin
      mem_clk_stall <= 1'b0;
      if (r_we) begin
        for (int i = 0; i < 4; i++)
          if (i == 0 || (i == 1 && r_mask[1]) ||
              (i > 1 && r_mask[2]))
            bmem[8'(r_addr[7:0] + 8'(i))] <= r_wdata[8*i +: 8];
        mem_read_data <= 32'h0;
      end else begin
        mem_read_data <= rd_word(r_addr[7:0], r_mask);
      end
    end
  end

  task automatic do_req(
    input logic we, input logic [31:0] a, input logic [31:0] wd,
    input logic [1:0] sz, input logic sg, output res_t r);
    int s0;
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_wdata  = wd;
    req_size   = sz;
    req_signed = sg;
    r.rdy = req_ready;
    @(posedge clk); #1;
    r.acc = cyc;
    s0 = strobe_cyc;
    req_valid  = 1'b0;
    req_we     = ~we;
    req_addr   = 32'hA5A5_5A5A;
    req_wdata  = 32'h1234_5678;
    req_size   = ~sz;
    req_signed = ~sg;
    r.mask = mem_sign_mask;
    r.hold = 1'b1;
    r.lat  = 1;
    while (!resp_valid && r.lat < 40) begin
      if (mem_addr !== a || req_ready !== 1'b0)
        r.hold = 1'b0;
      @(posedge clk); #1;
      r.lat++;
    end
    if (!resp_valid)
      r.lat = -1;
    r.rd  = resp_rdata;
    r.flt = resp_fault;
    if (mem_addr !== a || req_ready !== 1'b0)
      r.hold = 1'b0;
    @(posedge clk); #1;
    r.one = (resp_valid === 1'b0) && (req_ready === 1'b1);
    r.strobes = strobe_cyc - s0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_size = '0;
    req_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({req_ready, resp_valid, resp_fault, mem_memread,
         mem_memwrite, mem_sign_mask} !== 9'b1_0000_0000)
      $display("FAIL reset_ctl: got %b want %b",
        {req_ready, resp_valid, resp_fault, mem_memread,
         mem_memwrite, mem_sign_mask}, 9'b1_0000_0000);
    else n_pass++;
    n_chk++;
    if ({resp_rdata, mem_addr, mem_write_data} !== 96'h0)
      $display("FAIL reset_data: got %h want 0",
        {resp_rdata, mem_addr, mem_write_data});
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_store_load;
    res_t r;
    do_req(1'b1, 32'h4010, 32'hDEAD_BEEF, 2'b10, 1'b1, r);
    n_chk++;
    if (r.lat !== 4)
      $display("FAIL st_latency: got %0d want 4", r.lat);
    else n_pass++;
    n_chk++;
    if ({r.flt, r.rd} !== 33'h0)
      $display("FAIL st_resp: got fault %b rdata %h want 0 0",
        r.flt, r.rd);
    else n_pass++;
    n_chk++;
    if (r.mask !== 4'b0111)
      $display("FAIL st_mask: got %b want 0111", r.mask);
    else n_pass++;
    n_chk++;
    if (!(r.rdy && r.hold && r.one && r.strobes == 1))
      $display("FAIL st_proto: got rdy %b hold %b one %b strb %0d want 1 1 1 1",
        r.rdy, r.hold, r.one, r.strobes);
    else n_pass++;
    do_req(1'b0, 32'h4010, 32'h0, 2'b10, 1'b0, r);
    n_chk++;
    if (r.rd !== 32'hDEAD_BEEF || r.flt !== 1'b0)
      $display("FAIL ld_word: got %h/%b want deadbeef/0", r.rd, r.flt);
    else n_pass++;
    n_chk++;
    if (r.lat !== 4 || r.strobes !== 1)
      $display("FAIL ld_timing: got lat %0d strb %0d want 4 1",
        r.lat, r.strobes);
    else n_pass++;
  endtask

  task automatic test_sign_ext;
    res_t r;
    do_req(1'b1, 32'h4020, 32'h0000_80FF, 2'b10, 1'b0, r);
    do_req(1'b0, 32'h4021, 32'h0, 2'b00, 1'b1, r);
    n_chk++;
    if (r.rd !== 32'hFFFF_FF80 || r.mask !== 4'b1001)
      $display("FAIL ld_sbyte: got %h mask %b want ffffff80 1001",
        r.rd, r.mask);
    else n_pass++;
    do_req(1'b0, 32'h4021, 32'h0, 2'b00, 1'b0, r);
    n_chk++;
    if (r.rd !== 32'h0000_0080 || r.mask !== 4'b0001)
      $display("FAIL ld_ubyte: got %h mask %b want 00000080 0001",
        r.rd, r.mask);
    else n_pass++;
    do_req(1'b0, 32'h4020, 32'h0, 2'b01, 1'b1, r);
    n_chk++;
    if (r.rd !== 32'hFFFF_80FF || r.mask !== 4'b1011)
      $display("FAIL ld_shalf: got %h mask %b want ffff80ff 1011",
        r.rd, r.mask);
    else n_pass++;
    do_req(1'b0, 32'h4020, 32'h0, 2'b11, 1'b1, r);
    n_chk++;
    if (r.rd !== 32'h0000_80FF || r.mask !== 4'b1111)
      $display("FAIL ld_size3: got %h mask %b want 000080ff 1111",
        r.rd, r.mask);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    res_t r0;
    res_t r1;
    res_t r2;
    int p0;
    p0 = stall_pulses;
    do_req(1'b0, 32'h4010, 32'h0, 2'b10, 1'b0, r0);
    do_req(1'b0, 32'h4020, 32'h0, 2'b10, 1'b0, r1);
    do_req(1'b0, 32'h4010, 32'h0, 2'b10, 1'b0, r2);
    n_chk++;
    if (r1.acc - r0.acc != 5 || r2.acc - r1.acc != 5)
      $display("FAIL b2b_rate: got %0d %0d want 5 5",
        r1.acc - r0.acc, r2.acc - r1.acc);
    else n_pass++;
    n_chk++;
    if (stall_pulses - p0 != 3 ||
        r0.strobes + r1.strobes + r2.strobes != 3)
      $display("FAIL b2b_access: got stalls %0d strobes %0d want 3 3",
        stall_pulses - p0, r0.strobes + r1.strobes + r2.strobes);
    else n_pass++;
    n_chk++;
    if (r0.rd !== 32'hDEAD_BEEF || r1.rd !== 32'h0000_80FF ||
        r2.rd !== 32'hDEAD_BEEF)
      $display("FAIL b2b_data: got %h %h %h want deadbeef 000080ff deadbeef",
        r0.rd, r1.rd, r2.rd);
    else n_pass++;
  endtask

  task automatic test_timeout;
    res_t r;
    rmode = 1;
    do_req(1'b0, 32'h4010, 32'h0, 2'b10, 1'b0, r);
    n_chk++;
    if (r.lat !== 18 || r.flt !== 1'b1 || r.rd !== 32'h0)
      $display("FAIL to_stuck: got lat %0d fault %b rdata %h want 18 1 0",
        r.lat, r.flt, r.rd);
    else n_pass++;
    n_chk++;
    if (!r.one || r.strobes != 1)
      $display("FAIL to_stuck_after: got one %b strb %0d want 1 1",
        r.one, r.strobes);
    else n_pass++;
    rmode = 0;
    repeat (3) @(posedge clk);
    #1;
    rmode = 2;
    do_req(1'b0, 32'h4010, 32'h0, 2'b10, 1'b0, r);
    n_chk++;
    if (r.lat !== 18 || r.flt !== 1'b1 || r.rd !== 32'h0 || !r.one)
      $display("FAIL to_silent: got lat %0d fault %b rdata %h one %b want 18 1 0 1",
        r.lat, r.flt, r.rd, r.one);
    else n_pass++;
    rmode = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    res_t r;
    int n0;
    rmode = 1;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 32'h4010;
    req_size = 2'b10;
    req_signed = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n0 = resp_cnt;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if ({req_ready, resp_valid, resp_fault, mem_memread,
         mem_memwrite, mem_sign_mask} !== 9'b1_0000_0000 ||
        {resp_rdata, mem_addr, mem_write_data} !== 96'h0)
      $display("FAIL mid_reset_out: got ctl %b addr %h want 100000000 0",
        {req_ready, resp_valid, resp_fault, mem_memread,
         mem_memwrite, mem_sign_mask}, mem_addr);
    else n_pass++;
    rmode = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_chk++;
    if (resp_cnt != n0)
      $display("FAIL mid_reset_noresp: got %0d responses want 0",
        resp_cnt - n0);
    else n_pass++;
    do_req(1'b0, 32'h4010, 32'h0, 2'b10, 1'b0, r);
    n_chk++;
    if (r.rd !== 32'hDEAD_BEEF || r.lat !== 4 || r.flt !== 1'b0)
      $display("FAIL mid_reset_after: got %h lat %0d fault %b want deadbeef 4 0",
        r.rd, r.lat, r.flt);
    else n_pass++;
  endtask

  task automatic test_misaligned;
    res_t r;
    int e_lat;
    logic e_flt;
    logic [31:0] e_wd;
    logic [31:0] e_hw;
    int e_strb;
`ifdef DMEM_INIT_ALIGN_CHECK_EN
    e_lat  = 1;
    e_flt  = 1'b1;
    e_wd   = 32'h0;
    e_hw   = 32'h0;
    e_strb = 0;
`else
    e_lat  = 4;
    e_flt  = 1'b0;
    e_wd   = 32'h5544_3322;
    e_hw   = 32'h0000_2211;
    e_strb = 1;
`endif
    do_req(1'b1, 32'h4000, 32'h3322_1100, 2'b10, 1'b0, r);
    do_req(1'b1, 32'h4004, 32'h7766_5544, 2'b10, 1'b0, r);
    do_req(1'b0, 32'h4002, 32'h0, 2'b10, 1'b0, r);
    n_chk++;
    if (r.lat !== e_lat || r.flt !== e_flt || r.strobes != e_strb)
      $display("FAIL mis_word_ctl: got lat %0d fault %b strb %0d want %0d %b %0d",
        r.lat, r.flt, r.strobes, e_lat, e_flt, e_strb);
    else n_pass++;
    n_chk++;
    if (r.rd !== e_wd || !r.one)
      $display("FAIL mis_word_data: got %h one %b want %h 1",
        r.rd, r.one, e_wd);
    else n_pass++;
    do_req(1'b0, 32'h4001, 32'h0, 2'b01, 1'b0, r);
    n_chk++;
    if (r.lat !== e_lat || r.flt !== e_flt || r.rd !== e_hw)
      $display("FAIL mis_half: got lat %0d fault %b rdata %h want %0d %b %h",
        r.lat, r.flt, r.rd, e_lat, e_flt, e_hw);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_store_load();
    test_sign_ext();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_misaligned();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
